// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives the ALU control bundle and datapath enables, and raises precise traps.
module mips_mc_control #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter bit          EXC_ENABLE  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    input  logic       mem_ready,
    output logic       alu_src,
    output logic [3:0] alu_control,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       i_or_d,
    output logic       ir_en,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       reg_wr,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       exc_ovf,
    output logic       exc_bus,
    output logic       exc_ill
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JUMP, S_TRAP
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE, CAUSE_OVF, CAUSE_BUS, CAUSE_ILL
    } cause_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

    state_t     state;
    cause_t     cause;
    logic [7:0] wait_cnt;

    logic       r_legal;
    logic [3:0] r_code;
    logic       r_traps;
    logic       wait_expired;
    logic       ovf_trap;

    always_comb begin
        r_legal = 1'b1;
        r_code  = 4'b0000;
        case (funct)
            6'b100000: r_code = 4'b0000;
            6'b100001: r_code = 4'b0001;
            6'b100010: r_code = 4'b0010;
            6'b100011: r_code = 4'b0011;
            6'b100100: r_code = 4'b0100;
            6'b100101: r_code = 4'b0101;
            6'b000000: r_code = 4'b0110;
            6'b000010: r_code = 4'b0111;
            6'b101010: r_code = 4'b1000;
            default:   r_legal = 1'b0;
        endcase
    end

    // Only signed add/sub trap; the unsigned forms and MEMADR's ADDU never do.
    assign r_traps      = (funct == 6'b100000) || (funct == 6'b100010);
    assign ovf_trap     = overflow && EXC_ENABLE;
    assign wait_expired = !mem_ready && (wait_cnt == WAIT_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cause    <= CAUSE_NONE;
            wait_cnt <= 8'd0;
        end else begin
            // Counter is zero in every non-waiting state, so each wait starts from 0.
            wait_cnt <= 8'd0;
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready) begin
                        state <= S_DECODE;
                    end else if (wait_expired) begin
                        state <= S_TRAP;
                        cause <= CAUSE_BUS;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    case (opcode)
                        OP_RTYPE: begin
                            if (r_legal) begin
                                state <= S_EXEC_R;
                            end else begin
                                state <= S_TRAP;
                                cause <= CAUSE_ILL;
                            end
                        end
                        OP_LW, OP_SW:   state <= S_MEMADR;
                        OP_ADDI:        state <= S_EXEC_I;
                        OP_BEQ, OP_BNE: state <= S_BRANCH;
                        OP_J:           state <= S_JUMP;
                        default: begin
                            state <= S_TRAP;
                            cause <= CAUSE_ILL;
                        end
                    endcase
                end
                S_EXEC_R: begin
                    if (ovf_trap && r_traps) begin
                        state <= S_TRAP;
                        cause <= CAUSE_OVF;
                    end else begin
                        state <= S_ALUWB;
                    end
                end
                S_EXEC_I: begin
                    if (ovf_trap) begin
                        state <= S_TRAP;
                        cause <= CAUSE_OVF;
                    end else begin
                        state <= S_ALUWB;
                    end
                end
                S_MEMADR: state <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD, S_MEMWR: begin
                    if (mem_ready) begin
                        state <= (state == S_MEMRD) ? S_MEMWB : S_FETCH;
                    end else if (wait_expired) begin
                        state <= S_TRAP;
                        cause <= CAUSE_BUS;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_ALUWB, S_MEMWB, S_BRANCH, S_JUMP, S_TRAP: state <= S_FETCH;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        alu_src     = 1'b0;
        alu_control = 4'b0000;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        i_or_d      = 1'b0;
        ir_en       = 1'b0;
        pc_en       = 1'b0;
        pc_src      = 2'b00;
        reg_wr      = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        exc_ovf     = 1'b0;
        exc_bus     = 1'b0;
        exc_ill     = 1'b0;
        case (state)
            S_FETCH: begin
                mem_rd = 1'b1;
                ir_en  = mem_ready;
                pc_en  = mem_ready;
            end
            S_DECODE: alu_src = 1'b1;
            S_MEMADR: begin
                alu_src     = 1'b1;
                alu_control = 4'b0001;
            end
            S_MEMRD: begin
                mem_rd = 1'b1;
                i_or_d = 1'b1;
            end
            S_MEMWR: begin
                mem_wr = 1'b1;
                i_or_d = 1'b1;
            end
            S_MEMWB: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_EXEC_R: alu_control = r_code;
            S_EXEC_I: alu_src = 1'b1;
            S_ALUWB: begin
                reg_wr  = 1'b1;
                reg_dst = (opcode == OP_RTYPE);
            end
            S_BRANCH: begin
                alu_control = (opcode == OP_BNE) ? 4'b1010 : 4'b1001;
                pc_src      = 2'b01;
                pc_en       = (opcode == OP_BNE) ? !zero : zero;
            end
            S_JUMP: begin
                pc_en  = 1'b1;
                pc_src = 2'b10;
            end
            S_TRAP: begin
                pc_en   = 1'b1;
                pc_src  = 2'b11;
                exc_ovf = (cause == CAUSE_OVF);
                exc_bus = (cause == CAUSE_BUS);
                exc_ill = (cause == CAUSE_ILL);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_mc_control.sv
// Random instruction streams against a per-instruction cycle-sequence model of
// the control unit; expected output vectors are queued and compared each cycle.
module tb_mips_mc_control;

  localparam int TO = 16;
  localparam bit EXC = 1'b1;
  localparam int W = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic zero = 1'b0;
  logic overflow = 1'b0;
  logic mem_ready = 1'b0;
  logic alu_src, mem_rd, mem_wr, i_or_d, ir_en, pc_en, reg_wr, reg_dst, mem_to_reg;
  logic exc_ovf, exc_bus, exc_ill;
  logic [3:0] alu_control;
  logic [1:0] pc_src;

  mips_mc_control #(.MEM_TIMEOUT(TO), .EXC_ENABLE(EXC)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .overflow(overflow), .mem_ready(mem_ready), .alu_src(alu_src),
    .alu_control(alu_control), .mem_rd(mem_rd), .mem_wr(mem_wr), .i_or_d(i_or_d),
    .ir_en(ir_en), .pc_en(pc_en), .pc_src(pc_src), .reg_wr(reg_wr),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .exc_ovf(exc_ovf),
    .exc_bus(exc_bus), .exc_ill(exc_ill)
  );

  always #5 clk = ~clk;

  wire [W-1:0] act = {alu_src, alu_control, mem_rd, mem_wr, i_or_d, ir_en, pc_en,
                      pc_src, reg_wr, reg_dst, mem_to_reg, exc_ovf, exc_bus, exc_ill};

  logic [W-1:0] exp_q[$];
  string lbl_q[$];
  int errors = 0;
  int checks = 0;
  logic [W-1:0] mon_e;
  string mon_l;

  logic [5:0] rfn [9] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h00, 6'h02, 6'h2a};

  // Monitor: one expected vector per driven cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_l = lbl_q.pop_front();
      checks++;
      if (act !== mon_e) begin
        errors++;
        $display("FAIL %s: got %b expected %b (t=%0t)", mon_l, act, mon_e, $time);
      end
    end
  end

  function automatic logic [W-1:0] vec(input logic as, input logic [3:0] ac,
      input logic mrd, input logic mwr, input logic iod, input logic ire, input logic pce,
      input logic [1:0] pcs, input logic rw, input logic rd, input logic m2r,
      input logic [2:0] exc);
    return {as, ac, mrd, mwr, iod, ire, pce, pcs, rw, rd, m2r, exc};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic [W-1:0] e,
                      input string l, input logic mr, input logic z, input logic ov);
    @(posedge clk);
    #1;
    opcode = op; funct = fn; mem_ready = mr; zero = z; overflow = ov;
    exp_q.push_back(e);
    lbl_q.push_back(l);
  endtask

  // exc: {ovf,bus,ill}
  task automatic trap(input logic [5:0] op, input logic [5:0] fn, input logic [2:0] exc, input string l);
    step(op, fn, vec(0, 4'd0, 0, 0, 0, 0, 1, 2'b11, 0, 0, 0, exc), l, rb(), rb(), rb());
  endtask

  // Request held for `waits` not-ready cycles, then one ready cycle, unless the
  // not-ready run reaches TO cycles, which is a bus timeout.
  task automatic mem_phase(input logic [5:0] op, input logic [5:0] fn, input logic [W-1:0] busy,
                           input logic [W-1:0] done, input string l, input int waits,
                           output bit timed_out);
    int n;
    n = (waits < TO) ? waits : TO;
    for (int i = 0; i < n; i++) step(op, fn, busy, {l, "_wait"}, 1'b0, rb(), rb());
    timed_out = (waits >= TO);
    if (!timed_out) step(op, fn, done, {l, "_done"}, 1'b1, rb(), rb());
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw,
                       input logic z, input logic ov);
    bit to;
    bit r_ok;
    int idx;
    mem_phase(op, fn, vec(0, 4'd0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 3'b000),
              vec(0, 4'd0, 1, 0, 0, 1, 1, 2'b00, 0, 0, 0, 3'b000), "fetch", fw, to);
    if (to) begin
      trap(op, fn, 3'b010, "trap_bus_fetch");
      return;
    end
    step(op, fn, vec(1, 4'd0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 3'b000), "decode", rb(), rb(), rb());
    r_ok = 1'b0;
    idx = 0;
    for (int i = 0; i < 9; i++) if (fn == rfn[i]) begin r_ok = 1'b1; idx = i; end
    if (op == 6'd0 && r_ok) begin
      step(op, fn, vec(0, 4'(idx), 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 3'b000), "exec_r", rb(), rb(), ov);
      if (EXC && ov && (fn == 6'h20 || fn == 6'h22)) trap(op, fn, 3'b100, "trap_ovf_r");
      else step(op, fn, vec(0, 4'd0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 3'b000), "aluwb_r", rb(), rb(), rb());
    end else if (op == 6'd8) begin
      step(op, fn, vec(1, 4'd0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 3'b000), "exec_i", rb(), rb(), ov);
      if (EXC && ov) trap(op, fn, 3'b100, "trap_ovf_i");
      else step(op, fn, vec(0, 4'd0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 3'b000), "aluwb_i", rb(), rb(), rb());
    end else if (op == 6'd35 || op == 6'd43) begin
      step(op, fn, vec(1, 4'b0001, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 3'b000), "memadr", rb(), rb(), ov);
      if (op == 6'd35) begin
        mem_phase(op, fn, vec(0, 4'd0, 1, 0, 1, 0, 0, 2'b00, 0, 0, 0, 3'b000),
                  vec(0, 4'd0, 1, 0, 1, 0, 0, 2'b00, 0, 0, 0, 3'b000), "memrd", mw, to);
        if (to) trap(op, fn, 3'b010, "trap_bus_rd");
        else step(op, fn, vec(0, 4'd0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 1, 3'b000), "memwb", rb(), rb(), rb());
      end else begin
        mem_phase(op, fn, vec(0, 4'd0, 0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 3'b000),
                  vec(0, 4'd0, 0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 3'b000), "memwr", mw, to);
        if (to) trap(op, fn, 3'b010, "trap_bus_wr");
      end
    end else if (op == 6'd4 || op == 6'd5) begin
      step(op, fn, vec(0, (op == 6'd4) ? 4'b1001 : 4'b1010, 0, 0, 0, 0,
                       (op == 6'd4) ? z : !z, 2'b01, 0, 0, 0, 3'b000), "branch", rb(), z, rb());
    end else if (op == 6'd2) begin
      step(op, fn, vec(0, 4'd0, 0, 0, 0, 0, 1, 2'b10, 0, 0, 0, 3'b000), "jump", rb(), rb(), rb());
    end else begin
      trap(op, fn, 3'b001, "trap_ill");
    end
  endtask

  function automatic int rand_wait();
    return ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO - 1, TO)) : int'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [5:0] op, fn;
    // Outputs held at zero while in reset, then one IDLE cycle.
    for (int i = 0; i < 3; i++) step(6'd0, 6'd0, '0, "reset", rb(), rb(), rb());
    @(posedge clk); #1; rst_n = 1'b1; mem_ready = 1'b0;
    exp_q.push_back('0); lbl_q.push_back("idle");

    instr(6'd0, 6'h20, 0, 0, 1'b0, 1'b0);   // add
    instr(6'd35, 6'd0, 0, 3, 1'b0, 1'b0);   // lw, 3 wait states
    instr(6'd4, 6'd0, 0, 0, 1'b1, 1'b0);    // beq taken
    instr(6'd4, 6'd0, 0, 0, 1'b0, 1'b0);    // beq not taken
    instr(6'd5, 6'd0, 0, 0, 1'b0, 1'b0);    // bne taken
    instr(6'd0, 6'h22, 0, 0, 1'b0, 1'b1);   // sub overflow traps
    instr(6'd0, 6'h23, 0, 0, 1'b0, 1'b1);   // subu overflow ignored
    instr(6'd8, 6'd0, 0, 0, 1'b0, 1'b1);    // addi overflow traps
    instr(6'd0, 6'h20, TO, 0, 1'b0, 1'b0);  // fetch timeout
    instr(6'd0, 6'h20, TO - 1, 0, 1'b0, 1'b0); // ready on limit cycle
    instr(6'd63, 6'd0, 0, 0, 1'b0, 1'b0);   // illegal opcode
    instr(6'd0, 6'h3f, 0, 0, 1'b0, 1'b0);   // illegal funct
    instr(6'd43, 6'd0, 1, TO, 1'b0, 1'b0);  // sw timeout
    instr(6'd2, 6'd0, 0, 0, 1'b0, 1'b0);    // j

    // Reset during MEMWR: outputs must clear before the next clock edge.
    step(6'd43, 6'd0, vec(0, 4'd0, 1, 0, 0, 1, 1, 2'b00, 0, 0, 0, 3'b000), "rst_fetch", 1'b1, 1'b0, 1'b0);
    step(6'd43, 6'd0, vec(1, 4'd0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 3'b000), "rst_decode", 1'b0, 1'b0, 1'b0);
    step(6'd43, 6'd0, vec(1, 4'b0001, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 3'b000), "rst_memadr", 1'b0, 1'b0, 1'b0);
    step(6'd43, 6'd0, vec(0, 4'd0, 0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 3'b000), "rst_memwr", 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL async_reset: got %b expected %b", act, {W{1'b0}});
    end
    for (int i = 0; i < 2; i++) step(6'd43, 6'd0, '0, "in_reset", 1'b1, rb(), rb());
    @(posedge clk); #1; rst_n = 1'b1; mem_ready = 1'b0;
    exp_q.push_back('0); lbl_q.push_back("idle_after_reset");
    instr(6'd0, 6'h2a, 0, 0, 1'b0, 1'b0);   // slt

    for (int n = 0; n < 200; n++) begin
      fn = 6'($urandom_range(0, 63));
      case ($urandom_range(0, 9))
        0, 1: begin op = 6'd0; fn = rfn[$urandom_range(0, 8)]; end
        2: op = 6'd0;
        3: op = 6'd35;
        4: op = 6'd43;
        5: op = 6'd8;
        6: op = 6'd4;
        7: op = 6'd5;
        8: op = 6'd2;
        default: op = 6'($urandom_range(0, 63));
      endcase
      instr(op, fn, rand_wait(), rand_wait(), rb(), ($urandom_range(0, 3) == 0));
    end

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multicycle MIPS control FSM that produces the ALU control bundle (alu_src, alu_control) and datapath enables from instruction-register opcode/funct.
- Consumes the ALU status flags (zero, overflow) to resolve branches and signed-overflow traps.
- Sequences fetch, decode, execute, memory and writeback over a ready-handshaked memory port with a bus-timeout counter.
- Sits between the instruction register, the ALU and the PC/register-file write controls.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles waiting for mem_ready before a bus error; 1..255.
- EXC_ENABLE, 1: 1 = signed overflow traps; 0 = overflow is ignored and writeback proceeds.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  6  IR[31:26].
- funct  input  6  IR[5:0].
- zero  input  1  ALU zero flag.
- overflow  input  1  ALU signed overflow flag.
- mem_ready  input  1  memory completes the current read or write this cycle.
- alu_src  output  1  1 = SignImm operand, 0 = RD2 operand.
- alu_control  output  4  0000 ADD, 0001 ADDU, 0010 SUB, 0011 SUBU, 0100 AND, 0101 OR, 0110 SLL, 0111 SRL, 1000 SLT, 1001 BEQ, 1010 BNE.
- mem_rd  output  1  memory read request.
- mem_wr  output  1  memory write request.
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALU result register.
- ir_en  output  1  load the instruction register.
- pc_en  output  1  load the PC.
- pc_src  output  2  next-PC select: 00 = PC+4, 01 = branch target, 10 = jump target, 11 = exception vector.
- reg_wr  output  1  register-file write.
- reg_dst  output  1  destination select: 1 = rd, 0 = rt.
- mem_to_reg  output  1  writeback data select: 1 = memory data, 0 = ALU result.
- exc_ovf  output  1  one-cycle pulse on an overflow trap.
- exc_bus  output  1  one-cycle pulse on a memory timeout.
- exc_ill  output  1  one-cycle pulse on an illegal opcode or funct.

Behaviour:
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, JUMP, TRAP.
- Encoding: binary, registered state; all outputs decoded from state plus the listed inputs (Moore except where stated).
- Reset: rst_n low forces state IDLE, wait counter 0, exception cause 0, and every output 0 (alu_control 0000, pc_src 00).
- IDLE: drives all outputs 0; goes to FETCH on the next clock.
- FETCH: mem_rd=1, i_or_d=0.
  - On mem_ready: ir_en=1, pc_en=1, pc_src=00 in that same cycle, then DECODE.
  - Otherwise stay in FETCH and increment the wait counter.
- DECODE: one cycle; alu_control=0000, alu_src=1 (branch target precompute). Next state by opcode:
  - 000000 -> EXEC_R for funct 100000/100001/100010/100011/100100/100101/000000/000010/101010; any other funct -> TRAP (ill).
  - 100011 lw and 101011 sw -> MEMADR.
  - 001000 addi -> EXEC_I.
  - 000100 beq and 000101 bne -> BRANCH.
  - 000010 j -> JUMP.
  - Any other opcode -> TRAP (ill).
- EXEC_R: alu_src=0, alu_control from funct in the order add, addu, sub, subu, and, or, sll, srl, slt = 0000, 0001, 0010, 0011, 0100, 0101, 0110, 0111, 1000.
  - If overflow=1, EXC_ENABLE=1 and funct is add or sub -> TRAP (ovf); else -> ALUWB.
- EXEC_I: alu_src=1, alu_control=0000; overflow handled as in EXEC_R, else -> ALUWB.
- ALUWB: reg_wr=1, mem_to_reg=0; reg_dst=1 for R-type, 0 for addi; then FETCH.
- MEMADR: alu_src=1, alu_control=0001 (ADDU, never traps); next MEMRD for lw, MEMWR for sw.
- MEMRD: mem_rd=1, i_or_d=1; waits for mem_ready, then MEMWB.
- MEMWR: mem_wr=1, i_or_d=1; waits for mem_ready, then FETCH.
- MEMWB: reg_wr=1, mem_to_reg=1, reg_dst=0; then FETCH.
- BRANCH: alu_src=0, alu_control=1001 (beq) or 1010 (bne), pc_src=01.
  - pc_en = zero for beq, ~zero for bne (Mealy on zero); then FETCH.
- JUMP: pc_en=1, pc_src=10; then FETCH.
- TRAP: pc_en=1, pc_src=11; exactly one of exc_ovf, exc_bus, exc_ill pulses for this single cycle; no reg_wr or mem_wr; then FETCH.
- Wait counter:
  - 8-bit; cleared on entering FETCH, MEMRD or MEMWR, and whenever mem_ready=1.
  - If it reaches MEM_TIMEOUT-1 with mem_ready still 0, the next state is TRAP (bus) and the request drops the following cycle.
  - mem_ready on the limit cycle wins over the timeout.
- Latencies with zero wait states: R-type/addi 4 cycles, lw 5, sw 4, beq/bne/j 3.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- Reset asserted mid-instruction aborts immediately; no partial reg_wr or mem_wr completes.

Test Plan:
- add $3,$1,$2 (funct 100000), mem_ready always 1, overflow=0 -> FETCH, DECODE, EXEC_R (alu_control 0000, alu_src 0), ALUWB (reg_wr=1, reg_dst=1); 4 cycles.
- lw, mem_ready delayed 3 cycles in MEMRD -> MEMADR alu_control 0001, alu_src 1; MEMRD held 4 cycles; MEMWB mem_to_reg=1; total 8 cycles.
- beq with zero=1, then beq with zero=0, then bne with zero=0 -> pc_en=1 / 0 / 1 in BRANCH, each with pc_src=01.
- sub with overflow=1, EXC_ENABLE=1 -> TRAP: exc_ovf one pulse, pc_src=11, no reg_wr; repeat with subu -> ALUWB with reg_wr=1.
- mem_ready held 0 in FETCH, MEM_TIMEOUT=16 -> after 16 cycles TRAP with exc_bus=1, then FETCH; opcode 111111 -> TRAP with exc_ill=1.
- rst_n pulled low during MEMWR -> mem_wr drops asynchronously, all outputs 0; after release, IDLE for 1 cycle then FETCH.
